// File: rtl/mem_wait_pkg.sv
// Shared types and constants for the mem_wait wait-state memory model.
//   state_t       : controller state (IDLE, WAIT)
//   ERR_RDATA     : read data returned for out-of-range reads
//   MMIO_ADDR_DEF : default console write address
//   LAT_W         : width of the wait-state counter
//   byte_mask()   : expands a 4-bit byte strobe into a 32-bit bit mask
package mem_wait_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;
    localparam logic [31:0] MMIO_ADDR_DEF = 32'h1000_0000;
    localparam int          LAT_W         = 4;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_wait_array.sv
// Word-addressed storage with per-byte write enables and a registered read.
// Ports:
//   clk, resetn : clock / async active-low reset (read register only)
//   wr_en       : commit wdata bytes selected by wstrb to word addr
//   wstrb[3:0]  : byte write enables
//   rd_en       : load rdata from word addr on this edge
//   addr        : word address
//   wdata/rdata : write data / registered read data (holds between reads)
module mem_wait_array #(
    parameter int WORDS = 262144,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [3:0]    wstrb,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the storage array has no reset branch; clearing every word would
    // prevent RAM inference, and the contents are undefined after reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    rdata <= '0;
        else if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_wait.sv
// Native-bus (valid/ready, wstrb) test memory with configurable wait states.
// Instruction and data requests have separate latencies; out-of-range
// accesses complete with mem_err and 32'hDEAD_BEEF read data.
// Optional console port enabled by defining MEM_WAIT_MMIO_EN: a write to
// MMIO_ADDR pulses mmio_valid and captures the strobe-masked data.
// Ports:
//   clk, resetn            : clock / async active-low reset
//   mem_valid, mem_instr   : request valid / request is an instruction fetch
//   mem_addr, mem_wdata    : byte address ([1:0] ignored) / write data
//   mem_wstrb              : byte enables, 0 = read
//   mem_ready              : one-cycle completion pulse
//   mem_rdata, mem_err     : read data / out-of-range flag, valid with mem_ready
//   mmio_valid, mmio_data  : console write pulse / captured console data
module mem_wait
    import mem_wait_pkg::*;
#(
    parameter int          MEM_SIZE  = 1048576,
    parameter int          LAT_INSTR = 1,
    parameter int          LAT_DATA  = 1,
    parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        mmio_valid,
    output logic [31:0] mmio_data
);

    localparam int          WORDS     = MEM_SIZE / 4;
    localparam int          AW        = $clog2(WORDS);
    localparam int          LAT_MAX   = (1 << LAT_W) - 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE);
    localparam logic [LAT_W-1:0] LOAD_INSTR = LAT_W'(LAT_INSTR - 1);
    localparam logic [LAT_W-1:0] LOAD_DATA  = LAT_W'(LAT_DATA - 1);

    if (LAT_INSTR < 1 || LAT_INSTR > LAT_MAX) begin : g_bad_lat_instr
        $error("mem_wait: LAT_INSTR out of range 1..15");
    end
    if (LAT_DATA < 1 || LAT_DATA > LAT_MAX) begin : g_bad_lat_data
        $error("mem_wait: LAT_DATA out of range 1..15");
    end
    if (MMIO_ADDR[1:0] != 2'b00) begin : g_bad_mmio_addr
        $error("mem_wait: MMIO_ADDR must be word aligned");
    end

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       wstrb_q;
    logic             rd_err_q;

    logic             accept, complete;
    logic [31:0]      req_addr, req_wdata;
    logic [3:0]       req_wstrb;
    logic             is_write, in_range, mmio_hit;
    logic [31:0]      arr_rdata;

    // The ready cycle is a dead IDLE cycle: requests are only taken one edge later.
    assign accept = (state_q == IDLE) && mem_valid && !mem_ready;

    // A latency-1 request completes on its accept edge, before the capture
    // registers hold it, so the completion path sees the live bus in IDLE.
    assign req_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
    assign req_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
    assign req_wstrb = (state_q == IDLE) ? mem_wstrb : wstrb_q;

    assign is_write = (req_wstrb != 4'h0);
    assign in_range = ({1'b0, req_addr} < MEM_BYTES);

`ifdef MEM_WAIT_MMIO_EN
    assign mmio_hit = is_write && (req_addr[31:2] == MMIO_ADDR[31:2]);
`else
    assign mmio_hit = 1'b0;
`endif

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = mem_instr ? LOAD_INSTR : LOAD_DATA;
                    if (cnt_d == '0) complete = 1'b1;
                    else             state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_ready <= complete;
            mem_err   <= complete && !in_range && !mmio_hit;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            // Writes leave the read data (and its error select) untouched.
            if (complete && !is_write) rd_err_q <= !in_range;
        end
    end

    mem_wait_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (complete && is_write && in_range && !mmio_hit),
        .wstrb  (req_wstrb),
        .rd_en  (complete && !is_write && in_range),
        .addr   (req_addr[AW+1:2]),
        .wdata  (req_wdata),
        .rdata  (arr_rdata)
    );

    assign mem_rdata = rd_err_q ? ERR_RDATA : arr_rdata;

`ifdef MEM_WAIT_MMIO_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mmio_valid <= 1'b0;
            mmio_data  <= '0;
        end else begin
            mmio_valid <= complete && mmio_hit;
            if (complete && mmio_hit) mmio_data <= req_wdata & byte_mask(req_wstrb);
        end
    end
`else
    assign mmio_valid = 1'b0;
    assign mmio_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wait.sv
// Self-checking bench for mem_wait. Three instances with different latency
// pairs (1/1, 3/5, 2/4) share a per-cycle compare process that checks each
// against a transaction-level model (expected ready cycle, byte-masked word
// store, console register), plus literal expectations from hand computation.
`timescale 1ns/1ps
module tb_mem_wait;

    localparam int          NL       = 3;
    localparam int          MEM_SIZE = 1048576;
    localparam logic [31:0] MEM_END  = 32'h0010_0000;
    localparam logic [31:0] MMIO_A   = 32'h1000_0000;
`ifdef MEM_WAIT_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn     [NL];
    logic        mem_valid  [NL];
    logic        mem_instr  [NL];
    logic        mem_ready  [NL];
    logic [31:0] mem_addr   [NL];
    logic [31:0] mem_wdata  [NL];
    logic [3:0]  mem_wstrb  [NL];
    logic [31:0] mem_rdata  [NL];
    logic        mem_err    [NL];
    logic        mmio_valid [NL];
    logic [31:0] mmio_data  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_wait #(
            .MEM_SIZE  (MEM_SIZE),
            .LAT_INSTR (g == 0 ? 1 : (g == 1 ? 3 : 2)),
            .LAT_DATA  (g == 0 ? 1 : (g == 1 ? 5 : 4)),
            .MMIO_ADDR (MMIO_A)
        ) u_dut (
            .clk        (clk),
            .resetn     (resetn[g]),
            .mem_valid  (mem_valid[g]),
            .mem_instr  (mem_instr[g]),
            .mem_ready  (mem_ready[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_wstrb  (mem_wstrb[g]),
            .mem_rdata  (mem_rdata[g]),
            .mem_err    (mem_err[g]),
            .mmio_valid (mmio_valid[g]),
            .mmio_data  (mmio_data[g])
        );
    end

    // ---------------- model ----------------
    typedef struct {
        bit          instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    req_t        preq     [NL];
    bit          pend     [NL];
    int          rdy_cyc  [NL];
    int          last_acc [NL];
    logic [31:0] m_rdata  [NL];
    logic [31:0] m_mmio   [NL];
    logic [31:0] mdl      [int];
    logic [31:0] obs_rdata [NL];
    logic        obs_err   [NL];
    logic        obs_mv    [NL];
    int          obs_cyc   [NL];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int g, input bit instr);
        case (g)
            0:       return 1;
            1:       return instr ? 3 : 5;
            default: return instr ? 2 : 4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s lane%0d cycle %0d: got %h expected %h", name, g, cyc, act, exp);
        end
    endtask

    task automatic compare_lane(input int g);
        bit          exp_rdy, rd, inr, hit;
        int          key;
        logic [31:0] m, word;
        if (mem_ready[g] === 1'b1) obs_cyc[g] = cyc;
        exp_rdy = pend[g] && (cyc == rdy_cyc[g]);
        check("ready", g, 32'(mem_ready[g]), 32'(exp_rdy));
        if (exp_rdy) begin
            rd  = (preq[g].wstrb == 4'h0);
            inr = (preq[g].addr < MEM_END);
            hit = MMIO_EN && !rd && ((preq[g].addr & ~32'h3) == MMIO_A);
            key = g * (MEM_SIZE / 4) + int'(preq[g].addr >> 2);
            m   = mask_of(preq[g].wstrb);
            if (rd) begin
                if (inr) m_rdata[g] = mdl.exists(key) ? mdl[key] : 32'h0;
                else     m_rdata[g] = 32'hDEAD_BEEF;
            end else if (hit) begin
                m_mmio[g] = preq[g].wdata & m;
            end else if (inr) begin
                word = mdl.exists(key) ? mdl[key] : 32'h0;
                mdl[key] = (word & ~m) | (preq[g].wdata & m);
            end
            check("rdata", g, mem_rdata[g], m_rdata[g]);
            check("err", g, 32'(mem_err[g]), 32'(!hit && !inr));
            check("mmio_valid", g, 32'(mmio_valid[g]), 32'(hit));
            obs_rdata[g] = mem_rdata[g];
            obs_err[g]   = mem_err[g];
            obs_mv[g]    = mmio_valid[g];
            pend[g]      = 1'b0;
        end else begin
            check("mmio_idle", g, 32'(mmio_valid[g]), 32'h0);
        end
        check("mmio_data", g, mmio_data[g], m_mmio[g]);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) compare_lane(g);
    end

    // ---------------- driver ----------------
    // Called at a negedge with the lane free; returns at the negedge after the
    // ready cycle, the earliest point a new request may be presented.
    task automatic issue(input int g, input bit instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input bit hold);
        int t, r;
        mem_valid[g] = 1'b1;
        mem_instr[g] = instr;
        mem_addr[g]  = addr;
        mem_wdata[g] = wdata;
        mem_wstrb[g] = wstrb;
        t = cyc + 1;
        r = t + lat_of(g, instr) - 1;
        preq[g]     = '{instr, addr, wdata, wstrb};
        rdy_cyc[g]  = r;
        last_acc[g] = t;
        pend[g]     = 1'b1;
        @(negedge clk);
        if (!hold) mem_valid[g] = 1'b0;
        // Bus changes after accept must not affect the request in flight.
        mem_instr[g] = 1'($urandom_range(0, 1));
        mem_addr[g]  = $urandom;
        mem_wdata[g] = $urandom;
        mem_wstrb[g] = 4'($urandom_range(0, 15));
        while (cyc < r + 1) @(negedge clk);
        if (!hold) begin
            mem_addr[g]  = '0;
            mem_wstrb[g] = '0;
        end
    endtask

    logic [31:0] pool [8] = '{32'h0, 32'h40, 32'h100, 32'h200,
                              32'h3FC, 32'h1234, 32'h8000, 32'hF_FFFC};

    task automatic run_random(input int g, input int n);
        int          r;
        logic [31:0] a;
        logic [3:0]  s;
        bit          hold;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = pool[r] | 32'($urandom_range(0, 3));
            else if (r == 8) a = $urandom_range(0, 1) ? MEM_END + 32'(4 * $urandom_range(0, 1000))
                                                      : ($urandom | 32'h8000_0000);
            else             a = MMIO_A | 32'($urandom_range(0, 3));
            s    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            hold = (i < n - 1) && ($urandom_range(0, 1) == 1);
            issue(g, 1'($urandom_range(0, 1)), a, $urandom, s, hold);
            if (!hold && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic reset_lane(input int g, input bit level);
        @(negedge clk);
        #2;
        resetn[g] = level;
        if (!level) begin
            pend[g]    = 1'b0;
            m_rdata[g] = '0;
            m_mmio[g]  = '0;
        end
    endtask

    task automatic check_reset_values(input int g);
        check("rst_ready", g, 32'(mem_ready[g]), 32'h0);
        check("rst_rdata", g, mem_rdata[g], 32'h0);
        check("rst_err", g, 32'(mem_err[g]), 32'h0);
        check("rst_mmio_valid", g, 32'(mmio_valid[g]), 32'h0);
        check("rst_mmio_data", g, mmio_data[g], 32'h0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    int acc1, rdy1;

    initial begin
        for (int g = 0; g < NL; g++) begin
            resetn[g] = 1'b0; mem_valid[g] = 1'b0; mem_instr[g] = 1'b0;
            mem_addr[g] = '0; mem_wdata[g] = '0; mem_wstrb[g] = '0;
            pend[g] = 1'b0; m_rdata[g] = '0; m_mmio[g] = '0; obs_cyc[g] = -1;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NL; g++) check_reset_values(g);
        @(negedge clk);
        #2;
        for (int g = 0; g < NL; g++) resetn[g] = 1'b1;
        @(negedge clk);

        // Preload the address pool of every lane with full-word writes.
        for (int g = 0; g < NL; g++)
            for (int i = 0; i < 8; i++) issue(g, 1'b0, pool[i], $urandom, 4'hF, 1'b0);

        // Lane 0, latency 1.
        issue(0, 1'b0, 32'h0, 32'h0000_1111, 4'hF, 1'b0);
        issue(0, 1'b0, 32'h100, 32'hCAFE_F00D, 4'hF, 1'b0);
        check("lat1_write", 0, 32'(obs_cyc[0] - last_acc[0]), 32'h0);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        check("lat1_read", 0, 32'(obs_cyc[0] - last_acc[0]), 32'h0);
        check("pin_cafe", 0, obs_rdata[0], 32'hCAFE_F00D);
        check("pin_cafe_err", 0, 32'(obs_err[0]), 32'h0);
        issue(0, 1'b0, 32'h200, 32'h1122_3344, 4'hF, 1'b0);
        issue(0, 1'b0, 32'h200, 32'hAABB_CCDD, 4'b0101, 1'b0);
        issue(0, 1'b0, 32'h202, 32'h0, 4'h0, 1'b0);
        check("pin_partial", 0, obs_rdata[0], 32'h11BB_33DD);
        issue(0, 1'b0, 32'hF_FFFC, 32'h7777_0001, 4'hF, 1'b0);
        issue(0, 1'b0, 32'hF_FFFC, 32'h0, 4'h0, 1'b0);
        check("pin_top_word", 0, obs_rdata[0], 32'h7777_0001);
        check("pin_top_err", 0, 32'(obs_err[0]), 32'h0);
        issue(0, 1'b0, MEM_END, 32'h0, 4'h0, 1'b0);
        check("pin_oor_rdata", 0, obs_rdata[0], 32'hDEAD_BEEF);
        check("pin_oor_rd_err", 0, 32'(obs_err[0]), 32'h1);
        issue(0, 1'b0, MEM_END, 32'h5A5A_5A5A, 4'hF, 1'b0);
        check("pin_oor_wr_err", 0, 32'(obs_err[0]), 32'h1);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("pin_word0", 0, obs_rdata[0], 32'h0000_1111);
        issue(0, 1'b0, MMIO_A, 32'h1234_5641, 4'h1, 1'b0);
`ifdef MEM_WAIT_MMIO_EN
        check("pin_mmio_valid", 0, 32'(obs_mv[0]), 32'h1);
        check("pin_mmio_data", 0, mmio_data[0], 32'h0000_0041);
        check("pin_mmio_err", 0, 32'(obs_err[0]), 32'h0);
`else
        check("pin_mmio_valid", 0, 32'(obs_mv[0]), 32'h0);
        check("pin_mmio_err", 0, 32'(obs_err[0]), 32'h1);
`endif
        issue(0, 1'b0, MMIO_A, 32'h0, 4'h0, 1'b0);
        check("pin_mmio_read_err", 0, 32'(obs_err[0]), 32'h1);
        // Back-to-back with valid held: exactly one idle cycle between pulses.
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
        rdy1 = obs_cyc[0];
        issue(0, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        check("b2b_gap_l1", 0, 32'(obs_cyc[0] - rdy1), 32'h2);

        // Lane 1, LAT_INSTR=3 / LAT_DATA=5.
        issue(1, 1'b0, 32'h100, 32'h5555_AAAA, 4'hF, 1'b0);
        issue(1, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        check("lat_instr3", 1, 32'(obs_cyc[1] + 1 - last_acc[1]), 32'h3);
        check("pin_instr_rd", 1, obs_rdata[1], 32'h5555_AAAA);
        issue(1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        check("lat_data5", 1, 32'(obs_cyc[1] + 1 - last_acc[1]), 32'h5);
        check("pin_data_rd", 1, obs_rdata[1], 32'h5555_AAAA);
        issue(1, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1);
        rdy1 = obs_cyc[1];
        issue(1, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        check("b2b_accept", 1, 32'(last_acc[1] - rdy1), 32'h2);
        check("b2b_gap_l3", 1, 32'(obs_cyc[1] - rdy1), 32'h4);

        // Lane 2, LAT_DATA=4: reset two cycles after accepting a write.
        issue(2, 1'b0, 32'h40, 32'h0BAD_F00D, 4'hF, 1'b0);
        issue(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        mem_valid[2] = 1'b1; mem_instr[2] = 1'b0; mem_addr[2] = 32'h40;
        mem_wdata[2] = 32'h1234_5678; mem_wstrb[2] = 4'hF;
        acc1 = cyc + 1;
        preq[2] = '{1'b0, 32'h40, 32'h1234_5678, 4'hF};
        rdy_cyc[2] = acc1 + 3;
        pend[2] = 1'b1;
        @(negedge clk);
        mem_valid[2] = 1'b0;
        reset_lane(2, 1'b0);
        #1;
        check_reset_values(2);
        reset_lane(2, 1'b1);
        repeat (4) @(negedge clk);
        check("rst_no_ready", 2, 32'(obs_cyc[2] < acc1), 32'h1);
        issue(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        check("pin_rst_keep", 2, obs_rdata[2], 32'h0BAD_F00D);

        // Randomized traffic on each lane.
        for (int g = 0; g < NL; g++) run_random(g, 150);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_wait.md
Name: mem_wait

Overview:
- Parametrised successor of the single-cycle testbench memory on the picorv32-style native bus (valid/ready, wstrb).
- Adds configurable wait states with separate instruction and data latencies, a registered MMIO console port and out-of-range error signalling.
- Sits between the core's native memory interface and the testbench; stands in for slow instruction and data memories in compression experiments.

Parameters:
- MEM_SIZE, 1048576, storage size in bytes; power of two, multiple of 4.
- LAT_INSTR, 1, cycles from accept to mem_ready for mem_instr=1 requests; range 1..15.
- LAT_DATA, 1, cycles from accept to mem_ready for mem_instr=0 requests; range 1..15.
- MMIO_ADDR, 32'h1000_0000, console write address.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  request valid.
- mem_instr  in  1  request is an instruction fetch.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 0 = read.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- mem_err  out  1  out-of-range access; valid while mem_ready=1.
- mmio_valid  out  1  one-cycle pulse on a console write.
- mmio_data  out  32  captured console write data.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: state=IDLE, mem_ready=0, mem_rdata=0, mem_err=0, mmio_valid=0, mmio_data=0, wait counter=0.
- Storage contents are not reset.
- FSM has two states, IDLE and WAIT.
- IDLE, mem_valid=1: capture addr, wdata, wstrb and the instr flag; load counter with LAT_INSTR-1 or LAT_DATA-1.
  - If the load value is 0, complete on the same edge.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each cycle; complete on the edge where counter==1 (or on entry with 1).
- Latency: with the request accepted at edge T, mem_ready is high for exactly the cycle after edge T+L-1.
  - L=1 gives ready in the cycle after accept, matching the old single-cycle model.
- Completion edge:
  - mem_ready<=1 for one cycle; state<=IDLE.
  - Read (wstrb==0): mem_rdata<=word[addr[31:2]].
  - Write: commit only the enabled bytes on this edge; mem_rdata is unchanged.
- mem_ready is never high for two consecutive cycles.
  - The IDLE cycle coinciding with the ready pulse ignores mem_valid; the next request is accepted at the earliest one edge later.
- Requests use the captured copies. Changes to mem_valid, mem_addr etc. during WAIT are ignored and the request always completes.
- Out of range (addr>=MEM_SIZE and not the MMIO hit):
  - Write: dropped.
  - Read: mem_rdata<=32'hDEAD_BEEF.
  - mem_err=1 alongside mem_ready.
  - Storage is unchanged in both cases.
- MMIO hit is a write with addr==MMIO_ADDR: see Optional Feature. A read of MMIO_ADDR is treated as out of range.
- Reset mid-WAIT: abort immediately; no write is committed and mem_ready stays 0.
- Latency counter is 4 bits wide; a parameter outside 1..15 is an elaboration error.

Optional Feature:
- Macro: MEM_WAIT_MMIO_EN.
- Defined: a write with addr==MMIO_ADDR completes with normal data latency.
  - mmio_data<=wdata with bytes masked by wstrb; disabled bytes read as 0.
  - mmio_valid=1 for one cycle coincident with mem_ready.
  - Storage is untouched; mem_err=0.
- Undefined: mmio_valid and mmio_data are tied to 0. MMIO_ADDR receives no special handling, so with the default MEM_SIZE it is out of range: write dropped, mem_err=1.

Decomposition:
- Package mem_wait_pkg holds:
  - state enum {IDLE, WAIT};
  - ERR_RDATA=32'hDEAD_BEEF;
  - default MMIO_ADDR;
  - LAT_W=4.
- One sub-module, mem_wait_array: word-addressed storage with a 4-bit byte-write and a registered read, parameter WORDS=MEM_SIZE/4. The FSM, counter and MMIO logic stay in mem_wait.

Test Plan:
- Latency 1, write then read: write 32'hCAFE_F00D to 0x100 with wstrb=4'hF, then read 0x100 → mem_ready one cycle after each accept, rdata=32'hCAFE_F00D, mem_err=0.
- Partial write: preload 0x200 with 32'h1122_3344, write 32'hAABB_CCDD with wstrb=4'b0101, read back → 32'h11BB_33DD.
- Split latency (LAT_INSTR=3, LAT_DATA=5): instruction read accepted at edge T → ready at T+3. Data read accepted at T → ready at T+5, with mem_addr toggled during WAIT having no effect. Back-to-back valid gives exactly one idle cycle between ready pulses.
- Out of range, MEM_SIZE default: read 0x0010_0000 → rdata=32'hDEAD_BEEF, mem_err=1. Write to the same address → err=1, and a later read of 0x0 is unchanged.
- MMIO with MEM_WAIT_MMIO_EN defined: write 32'h0000_0041 with wstrb=4'h1 to 0x1000_0000 → mmio_valid pulse with mem_ready, mmio_data=32'h41, err=0. With the macro undefined → mmio_valid stays 0 and err=1.
- Reset in WAIT: LAT_DATA=4, write accepted, resetn low for 1 cycle at accept+2 → no mem_ready, the target word keeps its old value, all outputs return to reset values.
